// File: rtl/reg_operand_fetch.sv
// Operand-fetch sequencer that serialises writeback and two-source reads onto a single-port register file.
// Optional OPFETCH_R0_ZERO_EN: register 0 reads as zero and ignores writes.
module reg_operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        rf_write,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata
);

`ifdef OPFETCH_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        CAP,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] rs1_q;
    logic [4:0] rs2_q;
    logic       wr_en;
    logic       zero_a;
    logic       zero_b;

    assign zero_a = R0_ZERO && (rs1_q == 5'd0);
    assign zero_b = R0_ZERO && (rs2_q == 5'd0);

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        rf_write  = 1'b0;
        rf_addr   = 5'd0;
        rf_wdata  = 32'd0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                wb_ready  = rst_n;
                req_ready = rst_n && !wb_valid;
                if (req_valid && req_ready)
                    state_nxt = RD1;
            end
            RD1: begin
                rf_addr   = rs1_q;
                state_nxt = RD2;
            end
            RD2: begin
                rf_addr   = rs2_q;
                state_nxt = CAP;
            end
            CAP: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                wb_ready = rst_n;
                if (op_ready)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A write to r0 is still handshaken when r0 is hardwired, just never issued
        wr_en = wb_valid && wb_ready && !(R0_ZERO && (wb_addr == 5'd0));
        if (wr_en) begin
            rf_write = 1'b1;
            rf_addr  = wb_addr;
            rf_wdata = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            op_valid <= 1'b0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                    end
                end
                RD2: begin
                    op_a <= zero_a ? 32'd0 : rf_rdata;
                end
                CAP: begin
                    op_b     <= zero_b ? 32'd0 : rf_rdata;
                    op_valid <= 1'b1;
                end
                HOLD: begin
                    if (op_ready)
                        op_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Scoreboard bench for reg_operand_fetch with a behavioural single-port register file.
module tb_reg_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        rf_write;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata = 32'd0;

    reg_operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .rs1(rs1), .rs2(rs2),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_write(rf_write), .rf_addr(rf_addr),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    always @(posedge clk) begin
        if (rf_write) mem[rf_addr] <= rf_wdata;
        rf_rdata <= mem[rf_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

`ifdef OPFETCH_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (op_valid && !prev_v) begin
                if (sb.size() == 0) timeout("op_valid_unexpected");
                else chk("latency", cyc, sb[0].acc + 4);
            end
            if (op_valid && op_ready) begin
                if (sb.size() == 0) begin
                    timeout("handshake_unexpected");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("op_a", op_a, e.a);
                    chk("op_b", op_b, e.b);
                end
            end
            prev_v = op_valid;
        end
    end

    task automatic req(input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] ea, input logic [31:0] eb);
        int n;
        exp_t e;
        rs1 = a;
        rs2 = b;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            timeout("req_accept");
        end else begin
            e.a = ea;
            e.b = eb;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        int n;
        wb_addr = a;
        wb_data = d;
        wb_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wb_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wb_ready) timeout("wb_accept");
        @(posedge clk);
        #1 wb_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        @(negedge clk);
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // reset behaviour with both requests pending
        req_valid = 1'b1;
        wb_valid = 1'b1;
        wb_addr = 5'd4;
        wb_data = 32'h4444_4444;
        #22;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        req_valid = 1'b0;
        wb_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // write then read the same register twice
        wr(5'd5, 32'hDEAD_BEEF);
        req(5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        drain();

        // writeback wins over a simultaneous request
        wb_addr = 5'd3;
        wb_data = 32'h0000_1234;
        wb_valid = 1'b1;
        rs1 = 5'd3;
        rs2 = 5'd5;
        req_valid = 1'b1;
        @(negedge clk);
        chk("prio_req_ready", req_ready, 0);
        chk("prio_wb_ready", wb_ready, 1);
        chk("prio_rf_write", rf_write, 1);
        @(posedge clk);
        #1 wb_valid = 1'b0;
        req(5'd3, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF);
        drain();

        // write during HOLD does not disturb captured operands
        op_ready = 1'b0;
        req(5'd1, 5'd7, 32'h0, 32'h0);
        n = 0;
        @(negedge clk);
        while (!op_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!op_valid) timeout("hold_op_valid");
        @(posedge clk);
        #1;
        wr(5'd7, 32'hFFFF_0000);
        @(negedge clk);
        chk("hold_op_valid", op_valid, 1);
        chk("hold_op_a", op_a, 32'h0);
        chk("hold_op_b", op_b, 32'h0);
        @(posedge clk);
        #1 op_ready = 1'b1;
        drain();
        req(5'd7, 5'd3, 32'hFFFF_0000, 32'h0000_1234);
        drain();

        // writeback arriving in RD1 stalls until HOLD
        req(5'd3, 5'd7, 32'h0000_1234, 32'hFFFF_0000);
        wb_addr = 5'd9;
        wb_data = 32'h0000_9999;
        wb_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_wb_ready", wb_ready, 0);
            chk("stall_rf_write", rf_write, 0);
        end
        @(negedge clk);
        chk("hold_wb_ready", wb_ready, 1);
        chk("hold_rf_write", rf_write, 1);
        chk("hold_rf_addr", rf_addr, 5'd9);
        @(posedge clk);
        #1 wb_valid = 1'b0;
        drain();
        req(5'd9, 5'd9, 32'h0000_9999, 32'h0000_9999);
        drain();

        // reset pulse during RD2 aborts the request
        req(5'd5, 5'd9, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        wb_addr = 5'd5;
        wb_data = 32'h1111_1111;
        wb_valid = 1'b1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_op_valid", op_valid, 0);
        chk("mid_rst_op_a", op_a, 0);
        chk("mid_rst_op_b", op_b, 0);
        chk("mid_rst_rf_write", rf_write, 0);
        chk("mid_rst_wb_ready", wb_ready, 0);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_op_valid", op_valid, 0);
        chk("post_rst_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req(5'd5, 5'd9, 32'hDEAD_BEEF, 32'h0000_9999);
        drain();

        // register 0 behaviour
        wb_addr = 5'd0;
        wb_data = 32'hA5A5_A5A5;
        wb_valid = 1'b1;
        @(negedge clk);
        chk("r0_wb_ready", wb_ready, 1);
        chk("r0_rf_write", rf_write, R0Z ? 32'd0 : 32'd1);
        @(posedge clk);
        #1 wb_valid = 1'b0;
        req(5'd0, 5'd1, R0Z ? 32'h0 : 32'hA5A5_A5A5, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
